prog_load_run_ctrl: RTL and testbench
=====================================

// Module: prog_load_run_ctrl
// PURPOSE
//  Sequences the CPU from program download to halt. Packs UART bytes into 16-bit instruction words
//  and writes them to instruction memory, starting at address 1. Detects end of download by idle timeout.
//  Then gates CPU execution in auto-run or single-step mode and drives the status LED flags.
//  Sits in TOP between the UART receiver, the debounced switches/buttons and the CPU core.
// PARAMETERS
//  ADDR_W        8      instruction memory address width; address 0 is reserved, never written
//  IDLE_TIMEOUT  50000  clk cycles with no rx byte that end a download (> 2 UART byte times)
// PORTS
//  clk            in   1       system clock
//  rst            in   1       asynchronous reset, active-high
//  rx_valid       in   1       1-cycle strobe, rx_data holds a received byte
//  rx_data        in   8       received byte
//  start_sw       in   1       level: 1 = run permitted (START_CPU)
//  step_mode      in   1       level: 1 = single-step, 0 = auto-run; sampled on READY->exec transition
//  next_pulse     in   1       1-cycle debounced BTNC pulse: execute next instruction in step mode
//  cpu_instr_done in   1       1-cycle strobe from CPU at end of each instruction
//  cpu_halt       in   1       level from CPU, HALT executed
//  imem_we        out  1       instruction memory write strobe
//  imem_addr      out  ADDR_W  write address
//  imem_wdata     out  16      write data {first byte, second byte}
//  max_addr_instr out  ADDR_W  address of last instruction written
//  load_done      out  1       download complete (instr_transmit_done)
//  load_err       out  1       odd byte count or address overflow during download
//  cpu_en         out  1       CPU may advance; CPU stalls at instruction boundary while 0
//  led_loading    out  1       RGB blue; led_ready out 1 RGB green; led_halted out 1 RGB red
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; wr_ptr=1; byte phase=HI; timeout counter=0.
//  - Reset mid-operation aborts everything; imem contents are not cleared; next download overwrites from addr 1.
//  - FSM states: IDLE, LOAD, READY, RUN, STEP_WAIT, STEP_EXEC, PAUSE, HALTED.
//  - IDLE: first rx_valid latches byte as HI -> LOAD.
//  - LOAD: rx_valid toggles phase; HI latched; LO completes word.
//    - Same cycle as LO: imem_we=1, imem_addr=wr_ptr, imem_wdata={HI,LO}, max_addr_instr<=wr_ptr, wr_ptr++.
//    - Word latency: 1 cycle from the LO byte strobe to imem_we.
//  - Timeout counter clears on every rx_valid and counts otherwise. At IDLE_TIMEOUT -> READY, load_done=1.
//    - If phase=LO pending, the half byte is discarded and load_err=1.
//    - If zero words were written, return to IDLE instead (no load_done).
//  - Overflow: a word arriving with wr_ptr wrapped to 0 (after 2^ADDR_W-1 words) is dropped.
//    - imem_we stays 0, load_err=1, max_addr_instr held at all-ones.
//  - READY: led_ready=1; cpu_en=0.
//    - start_sw=1 -> RUN if step_mode=0, else STEP_WAIT. step_mode is latched here.
//    - rx bytes in READY are ignored (no re-download until reset).
//  - RUN: cpu_en=1 continuously.
//  - STEP_WAIT: cpu_en=0; next_pulse -> STEP_EXEC.
//  - STEP_EXEC: cpu_en=1 until cpu_instr_done, then STEP_WAIT (exactly one instruction per pulse).
//    - next_pulse while already in STEP_EXEC is ignored.
//  - start_sw=0 in RUN/STEP_WAIT/STEP_EXEC -> PAUSE (cpu_en=0, stall at boundary). PAUSE returns to the saved state when start_sw=1.
//  - cpu_halt=1 in any exec state -> HALTED next cycle; cpu_en=0; led_halted=1.
//    - cpu_halt has priority over next_pulse/start_sw in the same cycle.
//    - HALTED exits only via rst.
//  - led_loading=1 in LOAD; led_ready=1 in READY..PAUSE; led_halted=1 in HALTED. Mutually exclusive.
//  - load_done stays 1 from READY until reset.
// TESTING
//  1. 22 bytes 41 26 81 80 ... E0 00, then idle
//     -> 11 writes: addr1=0x4126, addr2=0x8180, addr11=0xE000.
//     -> max_addr_instr=11; load_done rises IDLE_TIMEOUT cycles after the last byte; load_err=0.
//  2. 3 bytes 41 00 81, then idle
//     -> one write addr1=0x4100; load_done=1, load_err=1; max_addr_instr=1.
//  3. Step mode, 3-instruction program ending HALT, 3 next_pulse
//     -> cpu_en high only between each pulse and cpu_instr_done; HALTED after the 3rd; a 4th pulse has no effect.
//  4. Auto-run: start_sw 0->1 in READY -> cpu_en=1 next cycle.
//     -> start_sw low mid-run gives PAUSE with cpu_en=0; raising it resumes RUN.
//     -> cpu_halt then gives led_halted=1, cpu_en=0.
//  5. rst asserted during LOAD after 5 words, then 2 bytes 41 00
//     -> outputs 0 during rst; new word written at addr1; max_addr_instr=1.
//  6. 256 words streamed (ADDR_W=8)
//     -> addrs 1..255 written; 256th dropped; load_err=1; max_addr_instr=0xFF.

Source files
------------

// File: rtl/prog_load_run_ctrl.sv
// Packs UART bytes into 16-bit words for imem (from addr 1), ends download on idle timeout, then gates CPU run/step.
// Writes land 1 cycle after the LO byte; no backpressure on rx, the CPU is held at instruction boundaries via cpu_en.
module prog_load_run_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int IDLE_TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              start_sw,
    input  logic              step_mode,
    input  logic              next_pulse,
    input  logic              cpu_instr_done,
    input  logic              cpu_halt,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic [ADDR_W-1:0] max_addr_instr,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_en,
    output logic              led_loading,
    output logic              led_ready,
    output logic              led_halted
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_READY     = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_STEP_WAIT = 3'd4;
    localparam logic [2:0] S_STEP_EXEC = 3'd5;
    localparam logic [2:0] S_PAUSE     = 3'd6;
    localparam logic [2:0] S_HALTED    = 3'd7;

    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    logic [2:0]        state;
    logic [2:0]        saved_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              phase_lo;
    logic [7:0]        hi_byte;
    logic [CNT_W-1:0]  idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            saved_state    <= S_IDLE;
            wr_ptr         <= ADDR_W'(1);
            phase_lo       <= 1'b0;
            hi_byte        <= 8'd0;
            idle_cnt       <= '0;
            imem_we        <= 1'b0;
            imem_addr      <= '0;
            imem_wdata     <= 16'd0;
            max_addr_instr <= '0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        hi_byte  <= rx_data;
                        phase_lo <= 1'b1;
                        idle_cnt <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        if (!phase_lo) begin
                            hi_byte  <= rx_data;
                            phase_lo <= 1'b1;
                        end else begin
                            phase_lo <= 1'b0;
                            // wr_ptr==0 means the address space wrapped: drop the word
                            if (wr_ptr != '0) begin
                                imem_we        <= 1'b1;
                                imem_addr      <= wr_ptr;
                                imem_wdata     <= {hi_byte, rx_data};
                                max_addr_instr <= wr_ptr;
                                wr_ptr         <= wr_ptr + 1'b1;
                            end else begin
                                load_err <= 1'b1;
                            end
                        end
                    end else if (idle_cnt == CNT_LAST) begin
                        idle_cnt <= '0;
                        phase_lo <= 1'b0;
                        if (max_addr_instr != '0) begin
                            state     <= S_READY;
                            load_done <= 1'b1;
                            if (phase_lo) begin
                                load_err <= 1'b1;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (start_sw) begin
                        state <= step_mode ? S_STEP_WAIT : S_RUN;
                    end
                end
                S_RUN: begin
                    if (cpu_halt) begin
                        state <= S_HALTED;
                    end else if (!start_sw) begin
                        saved_state <= S_RUN;
                        state       <= S_PAUSE;
                    end
                end
                S_STEP_WAIT: begin
                    if (cpu_halt) begin
                        state <= S_HALTED;
                    end else if (!start_sw) begin
                        saved_state <= S_STEP_WAIT;
                        state       <= S_PAUSE;
                    end else if (next_pulse) begin
                        state <= S_STEP_EXEC;
                    end
                end
                S_STEP_EXEC: begin
                    if (cpu_halt) begin
                        state <= S_HALTED;
                    end else if (!start_sw) begin
                        // an instruction finishing in the same cycle must not be re-run on resume
                        saved_state <= cpu_instr_done ? S_STEP_WAIT : S_STEP_EXEC;
                        state       <= S_PAUSE;
                    end else if (cpu_instr_done) begin
                        state <= S_STEP_WAIT;
                    end
                end
                S_PAUSE: begin
                    if (cpu_halt) begin
                        state <= S_HALTED;
                    end else if (start_sw) begin
                        state <= saved_state;
                    end
                end
                default: state <= S_HALTED;
            endcase
        end
    end

    assign cpu_en      = (state == S_RUN) || (state == S_STEP_EXEC);
    assign led_loading = (state == S_LOAD);
    assign led_ready   = (state == S_READY) || (state == S_RUN) || (state == S_STEP_WAIT) ||
                         (state == S_STEP_EXEC) || (state == S_PAUSE);
    assign led_halted  = (state == S_HALTED);

endmodule

// File: tb/tb_prog_load_run_ctrl.sv
// Directed bench for prog_load_run_ctrl: download, timeout, overflow, run/step/pause/halt sequencing.
module tb_prog_load_run_ctrl;

    localparam int ADDR_W = 8;
    localparam int TO     = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              start_sw = 1'b0;
    logic              step_mode = 1'b0;
    logic              next_pulse = 1'b0;
    logic              cpu_instr_done = 1'b0;
    logic              cpu_halt = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic [ADDR_W-1:0] max_addr_instr;
    logic              load_done, load_err, cpu_en, led_loading, led_ready, led_halted;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wa_q[$];
    logic [15:0] wd_q[$];

    localparam logic [15:0] T1W [11] = '{16'h4126, 16'h8180, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                         16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978, 16'hE000};

    prog_load_run_ctrl #(.ADDR_W(ADDR_W), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .start_sw(start_sw), .step_mode(step_mode), .next_pulse(next_pulse),
        .cpu_instr_done(cpu_instr_done), .cpu_halt(cpu_halt),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .max_addr_instr(max_addr_instr), .load_done(load_done), .load_err(load_err),
        .cpu_en(cpu_en), .led_loading(led_loading), .led_ready(led_ready), .led_halted(led_halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; start_sw = 1'b0; step_mode = 1'b0;
        next_pulse = 1'b0; cpu_instr_done = 1'b0; cpu_halt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_load_done(input int budget);
        int n = 0;
        while (load_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL load_done_timeout: load_done=%b after %0d cycles, required 1", load_done, n);
        end
    endtask

    task automatic test_reset();
        logic [38:0] outs;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        outs = {imem_we, imem_addr, imem_wdata, max_addr_instr, load_done, load_err, cpu_en,
                led_loading, led_ready, led_halted};
        checks++;
        if (outs !== 39'd0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
        do_reset();
        outs = {imem_we, imem_addr, imem_wdata, max_addr_instr, load_done, load_err, cpu_en,
                led_loading, led_ready, led_halted};
        checks++;
        if (outs !== 39'd0) begin errors++; $display("FAIL post_reset_outputs: got %h required 0", outs); end
        // a lone HI byte with no word completed falls back to IDLE without load_done
        send_byte(8'h55);
        checks++;
        if (led_loading !== 1'b1) begin errors++; $display("FAIL single_byte_loading: got %b required 1", led_loading); end
        repeat (TO + 5) @(negedge clk);
        checks++;
        if ({load_done, led_loading, led_ready} !== 3'b000 || wa_q.size() != 0) begin
            errors++;
            $display("FAIL single_byte_idle: done/loading/ready=%b writes=%0d required 000/0",
                     {load_done, led_loading, led_ready}, wa_q.size());
        end
    endtask

    task automatic test_load_basic();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            send_byte(T1W[i][15:8]);
            if (i < 10) send_byte(T1W[i][7:0]);
        end
        checks++;
        if (led_loading !== 1'b1 || load_done !== 1'b0) begin
            errors++; $display("FAIL loading_led: loading=%b done=%b required 1/0", led_loading, load_done);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd11 || imem_wdata !== 16'hE000) begin
            errors++;
            $display("FAIL word_latency: we=%b addr=%h data=%h required 1/0b/e000", imem_we, imem_addr, imem_wdata);
        end
        repeat (TO - 1) @(negedge clk);
        checks++;
        if (load_done !== 1'b0) begin errors++; $display("FAIL load_done_early: got %b required 0", load_done); end
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1) begin errors++; $display("FAIL load_done_on_time: got %b required 1", load_done); end
        checks++;
        if (wa_q.size() != 11) begin errors++; $display("FAIL basic_write_count: got %0d required 11", wa_q.size()); end
        for (int i = 0; i < 11 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== 8'(i + 1) || wd_q[i] !== T1W[i]) begin
                errors++;
                $display("FAIL basic_write_%0d: addr=%h data=%h required %h/%h", i, wa_q[i], wd_q[i], 8'(i + 1), T1W[i]);
            end
        end
        checks++;
        if (max_addr_instr !== 8'd11 || load_err !== 1'b0 || led_ready !== 1'b1 || cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_final: max=%h err=%b ready=%b en=%b required 0b/0/1/0",
                     max_addr_instr, load_err, led_ready, cpu_en);
        end
    endtask

    task automatic test_odd_count();
        do_reset();
        send_byte(8'h41);
        send_byte(8'h00);
        send_byte(8'h81);
        wait_load_done(TO + 20);
        checks++;
        if (wa_q.size() != 1) begin errors++; $display("FAIL odd_write_count: got %0d required 1", wa_q.size()); end
        else begin
            checks++;
            if (wa_q[0] !== 8'd1 || wd_q[0] !== 16'h4100) begin
                errors++; $display("FAIL odd_write: addr=%h data=%h required 01/4100", wa_q[0], wd_q[0]);
            end
        end
        checks++;
        if (load_err !== 1'b1 || max_addr_instr !== 8'd1 || led_ready !== 1'b1) begin
            errors++;
            $display("FAIL odd_final: err=%b max=%h ready=%b required 1/01/1", load_err, max_addr_instr, led_ready);
        end
    endtask

    task automatic test_step_mode();
        do_reset();
        send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h22);
        send_byte(8'hF0); send_byte(8'h00);
        wait_load_done(TO + 20);
        step_mode = 1'b1;
        start_sw  = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_en !== 1'b0 || led_ready !== 1'b1) begin
            errors++; $display("FAIL step_wait_entry: en=%b ready=%b required 0/1", cpu_en, led_ready);
        end
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(negedge clk);
            checks++;
            if (cpu_en !== 1'b0) begin errors++; $display("FAIL step_idle_%0d: en=%b required 0", k, cpu_en); end
            next_pulse = 1'b1;
            @(negedge clk);
            next_pulse = 1'b0;
            checks++;
            if (cpu_en !== 1'b1) begin errors++; $display("FAIL step_exec_%0d: en=%b required 1", k, cpu_en); end
            @(negedge clk);
            next_pulse = 1'b1;
            @(negedge clk);
            next_pulse     = 1'b0;
            cpu_instr_done = 1'b1;
            if (k == 2) cpu_halt = 1'b1;
            checks++;
            if (cpu_en !== 1'b1) begin errors++; $display("FAIL step_hold_%0d: en=%b required 1", k, cpu_en); end
            @(negedge clk);
            cpu_instr_done = 1'b0;
            checks++;
            if (cpu_en !== 1'b0 || led_halted !== (k == 2)) begin
                errors++;
                $display("FAIL step_done_%0d: en=%b halted=%b required 0/%b", k, cpu_en, led_halted, (k == 2));
            end
        end
        next_pulse = 1'b1;
        @(negedge clk);
        next_pulse = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_en !== 1'b0 || led_halted !== 1'b1 || led_ready !== 1'b0) begin
            errors++;
            $display("FAIL step_after_halt: en=%b halted=%b ready=%b required 0/1/0", cpu_en, led_halted, led_ready);
        end
        cpu_halt = 1'b0;
    endtask

    task automatic test_autorun();
        do_reset();
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78);
        wait_load_done(TO + 20);
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_en !== 1'b0) begin errors++; $display("FAIL ready_no_run: en=%b required 0", cpu_en); end
        start_sw = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_en !== 1'b1) begin errors++; $display("FAIL run_start: en=%b required 1", cpu_en); end
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_en !== 1'b1 || led_ready !== 1'b1) begin
            errors++; $display("FAIL run_hold: en=%b ready=%b required 1/1", cpu_en, led_ready);
        end
        start_sw = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_en !== 1'b0 || led_ready !== 1'b1) begin
            errors++; $display("FAIL pause: en=%b ready=%b required 0/1", cpu_en, led_ready);
        end
        start_sw = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_en !== 1'b1) begin errors++; $display("FAIL resume: en=%b required 1", cpu_en); end
        cpu_halt   = 1'b1;
        start_sw   = 1'b0;
        next_pulse = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_en !== 1'b0 || led_halted !== 1'b1 || led_ready !== 1'b0) begin
            errors++;
            $display("FAIL halt: en=%b halted=%b ready=%b required 0/1/0", cpu_en, led_halted, led_ready);
        end
        cpu_halt   = 1'b0;
        next_pulse = 1'b0;
        start_sw   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_en !== 1'b0 || led_halted !== 1'b1) begin
            errors++; $display("FAIL halt_sticky: en=%b halted=%b required 0/1", cpu_en, led_halted);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [38:0] outs;
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i));
        checks++;
        if (max_addr_instr !== 8'd5) begin errors++; $display("FAIL pre_abort_max: got %h required 05", max_addr_instr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        outs = {imem_we, imem_addr, imem_wdata, max_addr_instr, load_done, load_err, cpu_en,
                led_loading, led_ready, led_halted};
        checks++;
        if (outs !== 39'd0) begin errors++; $display("FAIL abort_outputs: got %h required 0", outs); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
        send_byte(8'h41);
        send_byte(8'h00);
        wait_load_done(TO + 20);
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 8'd1 || wd_q[0] !== 16'h4100 || max_addr_instr !== 8'd1) begin
            errors++;
            $display("FAIL reload: writes=%0d max=%h required 1 write 01=4100, max 01", wa_q.size(), max_addr_instr);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] w;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            w = 16'(32'hA000 + i);
            if (i == 255) begin
                checks++;
                if (load_err !== 1'b0 || max_addr_instr !== 8'hFF) begin
                    errors++;
                    $display("FAIL full_no_err: err=%b max=%h required 0/ff", load_err, max_addr_instr);
                end
            end
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        wait_load_done(TO + 20);
        checks++;
        if (wa_q.size() != 255) begin errors++; $display("FAIL ovf_write_count: got %0d required 255", wa_q.size()); end
        for (int j = 0; j < wa_q.size() && j < 255; j++) begin
            checks++;
            if (wa_q[j] !== 8'(j + 1) || wd_q[j] !== 16'(32'hA000 + j)) begin
                errors++;
                $display("FAIL ovf_write_%0d: addr=%h data=%h required %h/%h", j, wa_q[j], wd_q[j],
                         8'(j + 1), 16'(32'hA000 + j));
            end
        end
        checks++;
        if (load_err !== 1'b1 || max_addr_instr !== 8'hFF || load_done !== 1'b1) begin
            errors++;
            $display("FAIL ovf_final: err=%b max=%h done=%b required 1/ff/1", load_err, max_addr_instr, load_done);
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_odd_count();
        test_step_mode();
        test_autorun();
        test_reset_mid_load();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
